pipeline_hazard_controller: RTL and testbench

- Central sequencing block for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB).
- Generates per-pipe enable and flush strobes for IF/ID, ID/EX, EX/MEM and MEM/WB, plus the PC write enable.
- Handles three events:
  - load-use stalls, detected between ID and EX;
  - control redirects resolved in MEM: taken BEQ/BNE, J/JAL and JR;
  - a multi-cycle data-memory wait that freezes the whole pipeline.
- Keeps event counters for performance checks on the board.

---
 rtl/pipeline_ctrl_pkg.sv | 27 ++
 rtl/pipeline_hazard_controller_event_counter.sv | 21 ++
 rtl/pipeline_hazard_controller.sv | 161 ++++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the 5-stage pipeline sequencing logic.
// The hazard controller and its helpers import this package.
package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      WAIT    = 2'd1,
      RELEASE = 2'd2
   } CtrlState;

   localparam logic [4:0]  REG_ZERO  = 5'd0;
   localparam logic [31:0] NOP_INSTR = 32'h0;

   // A load in EX whose destination is read by the instruction in ID needs one bubble.
   // Register $zero never creates a dependency because it is hard-wired.
   function automatic logic isLoadUse(
      input logic       exMemRead,
      input logic [4:0] exRt,
      input logic [4:0] idRs,
      input logic [4:0] idRt,
      input logic       idUsesRt
   );
      return exMemRead && (exRt != REG_ZERO) &&
             ((exRt == idRs) || (idUsesRt && (exRt == idRt)));
   endfunction

endpackage

// File: rtl/pipeline_hazard_controller_event_counter.sv
// Free-running event counter with synchronous clear.
// It wraps modulo 2^COUNT_W and is used for the board performance registers.
module event_counter #(
   parameter int COUNT_W = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               increment,
   output logic [COUNT_W-1:0] count
);

   // Clear on reset; otherwise advance by one whenever the strobe is high.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (increment) begin
         count <= count + COUNT_W'(1);
      end
   end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Central sequencing block for the 5-stage MIPS pipeline.
// It produces pipe enables, pipe flushes and the PC write enable for three
// situations: load-use stalls, redirects resolved in MEM, and the
// multi-cycle data-memory freeze. It also counts each kind of event.
module pipeline_hazard_controller
   import pipeline_ctrl_pkg::*;
#(
   parameter int MEM_WAIT_CYCLES = 0,
   parameter int COUNT_W         = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [4:0]         id_rs,
   input  logic [4:0]         id_rt,
   input  logic               id_uses_rt,
   input  logic               ex_mem_read,
   input  logic [4:0]         ex_rt,
   input  logic               mem_branch_taken,
   input  logic               mem_jump,
   input  logic               mem_jr,
   input  logic               mem_mem_read,
   input  logic               mem_mem_write,
   output logic               pc_enable,
   output logic               if_id_enable,
   output logic               id_ex_enable,
   output logic               ex_mem_enable,
   output logic               mem_wb_enable,
   output logic               if_id_flush,
   output logic               id_ex_flush,
   output logic               ex_mem_flush,
   output logic               busy,
   output logic [COUNT_W-1:0] stall_count,
   output logic [COUNT_W-1:0] flush_count,
   output logic [COUNT_W-1:0] freeze_count
);

   localparam int CNT_W = (MEM_WAIT_CYCLES > 0) ? $clog2(MEM_WAIT_CYCLES + 1) : 1;
   localparam bit FREEZE_EN = (MEM_WAIT_CYCLES > 0);
   localparam logic [CNT_W-1:0] WAIT_LOAD =
      CNT_W'((MEM_WAIT_CYCLES > 1) ? (MEM_WAIT_CYCLES - 1) : 0);

   CtrlState         state;
   CtrlState         nextState;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] nextCnt;

   logic redirect;
   logic loadUse;
   logic memAccess;
   logic holdAll;
   logic stallInc;
   logic flushInc;
   logic freezeInc;

   assign redirect  = mem_branch_taken | mem_jump | mem_jr;
   assign loadUse   = isLoadUse(ex_mem_read, ex_rt, id_rs, id_rt, id_uses_rt);
   assign memAccess = mem_mem_read | mem_mem_write;

   // State and wait-counter register; reset abandons any freeze in progress.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= nextState;
         cnt   <= nextCnt;
      end
   end

   // Next-state logic: a memory access in RUN starts the freeze, WAIT counts it
   // down, and RELEASE always returns to RUN so the held access can advance.
   always_comb begin
      nextState = state;
      nextCnt   = cnt;
      unique case (state)
         RUN: begin
            if (memAccess && FREEZE_EN) begin
               if (MEM_WAIT_CYCLES > 1) begin
                  nextState = WAIT;
                  nextCnt   = WAIT_LOAD;
               end else begin
                  nextState = RELEASE;
               end
            end
         end
         WAIT: begin
            nextCnt = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
               nextState = RELEASE;
            end
         end
         RELEASE: begin
            nextState = RUN;
         end
         default: begin
            nextState = RUN;
            nextCnt   = '0;
         end
      endcase
   end

   // Output logic: the freeze outranks redirects, and redirects outrank load-use.
   // RELEASE ignores the memory access because that instruction is already done.
   always_comb begin
      pc_enable     = 1'b1;
      if_id_enable  = 1'b1;
      id_ex_enable  = 1'b1;
      ex_mem_enable = 1'b1;
      mem_wb_enable = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_flush   = 1'b0;
      ex_mem_flush  = 1'b0;
      stallInc      = 1'b0;
      flushInc      = 1'b0;
      freezeInc     = 1'b0;
      busy          = (state != RUN);

      holdAll = (state == WAIT) || ((state == RUN) && memAccess && FREEZE_EN);

      if (holdAll) begin
         pc_enable     = 1'b0;
         if_id_enable  = 1'b0;
         id_ex_enable  = 1'b0;
         ex_mem_enable = 1'b0;
         mem_wb_enable = 1'b0;
         freezeInc     = 1'b1;
      end else if (redirect) begin
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         ex_mem_flush = 1'b1;
         flushInc     = 1'b1;
      end else if (loadUse) begin
         pc_enable    = 1'b0;
         if_id_enable = 1'b0;
         id_ex_flush  = 1'b1;
         stallInc     = 1'b1;
      end
   end

   event_counter #(.COUNT_W(COUNT_W)) stallCounter (
      .clk       (clk),
      .reset     (reset),
      .increment (stallInc),
      .count     (stall_count)
   );

   event_counter #(.COUNT_W(COUNT_W)) flushCounter (
      .clk       (clk),
      .reset     (reset),
      .increment (flushInc),
      .count     (flush_count)
   );

   event_counter #(.COUNT_W(COUNT_W)) freezeCounter (
      .clk       (clk),
      .reset     (reset),
      .increment (freezeInc),
      .count     (freeze_count)
   );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller.
// dutA uses a 3-cycle memory with 4-bit counters. dutB uses a single-cycle
// memory with 8-bit counters. Both instances share the same stimulus.
module tb_pipeline_hazard_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] idRs, idRt, exRt;
   logic       idUsesRt, exMemRead, memBranchTaken, memJump, memJr, memMemRead, memMemWrite;

   logic       aPc, aIfId, aIdEx, aExMem, aMemWb, aFlIfId, aFlIdEx, aFlExMem, aBusy;
   logic [3:0] aStall, aFlush, aFreeze;
   logic       bPc, bIfId, bIdEx, bExMem, bMemWb, bFlIfId, bFlIdEx, bFlExMem, bBusy;
   logic [7:0] bStall, bFlush, bFreeze;

   int checkCount = 0;
   int passCount  = 0;

   pipeline_hazard_controller #(.MEM_WAIT_CYCLES(3), .COUNT_W(4)) dutA (
      .clk(clk), .reset(reset), .id_rs(idRs), .id_rt(idRt), .id_uses_rt(idUsesRt),
      .ex_mem_read(exMemRead), .ex_rt(exRt), .mem_branch_taken(memBranchTaken),
      .mem_jump(memJump), .mem_jr(memJr), .mem_mem_read(memMemRead),
      .mem_mem_write(memMemWrite), .pc_enable(aPc), .if_id_enable(aIfId),
      .id_ex_enable(aIdEx), .ex_mem_enable(aExMem), .mem_wb_enable(aMemWb),
      .if_id_flush(aFlIfId), .id_ex_flush(aFlIdEx), .ex_mem_flush(aFlExMem),
      .busy(aBusy), .stall_count(aStall), .flush_count(aFlush), .freeze_count(aFreeze)
   );

   pipeline_hazard_controller #(.MEM_WAIT_CYCLES(0), .COUNT_W(8)) dutB (
      .clk(clk), .reset(reset), .id_rs(idRs), .id_rt(idRt), .id_uses_rt(idUsesRt),
      .ex_mem_read(exMemRead), .ex_rt(exRt), .mem_branch_taken(memBranchTaken),
      .mem_jump(memJump), .mem_jr(memJr), .mem_mem_read(memMemRead),
      .mem_mem_write(memMemWrite), .pc_enable(bPc), .if_id_enable(bIfId),
      .id_ex_enable(bIdEx), .ex_mem_enable(bExMem), .mem_wb_enable(bMemWb),
      .if_id_flush(bFlIfId), .id_ex_flush(bFlIdEx), .ex_mem_flush(bFlExMem),
      .busy(bBusy), .stall_count(bStall), .flush_count(bFlush), .freeze_count(bFreeze)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Drive every hazard-related input for the coming cycle.
   task automatic applyStimulus(
      input logic [4:0] rs, input logic [4:0] rt, input logic usesRt,
      input logic exRead, input logic [4:0] exDest,
      input logic br, input logic jmp, input logic jr,
      input logic mRead, input logic mWrite
   );
      idRs = rs; idRt = rt; idUsesRt = usesRt;
      exMemRead = exRead; exRt = exDest;
      memBranchTaken = br; memJump = jmp; memJr = jr;
      memMemRead = mRead; memMemWrite = mWrite;
   endtask

   task automatic idleInputs();
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
   endtask

   // Sample combinational outputs in the middle of a cycle.
   task automatic midCycle();
      @(negedge clk);
   endtask

   // Move just past the next rising edge so inputs can change safely.
   task automatic endCycle();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [4:0] enA();
      return {aPc, aIfId, aIdEx, aExMem, aMemWb};
   endfunction
   function automatic logic [2:0] flA();
      return {aFlIfId, aFlIdEx, aFlExMem};
   endfunction
   function automatic logic [4:0] enB();
      return {bPc, bIfId, bIdEx, bExMem, bMemWb};
   endfunction
   function automatic logic [2:0] flB();
      return {bFlIfId, bFlIdEx, bFlExMem};
   endfunction

   // Directed sequence; each step carries its expected values inline.
   initial begin
      reset = 1'b1;
      idleInputs();
      endCycle();
      endCycle();
      reset = 1'b0;

      // Reset state
      midCycle();
      checkOutput("resetEnables", 32'(enA()), 32'h1F);
      checkOutput("resetFlushes", 32'(flA()), 32'h0);
      checkOutput("resetBusy", 32'(aBusy), 32'h0);
      checkOutput("resetCounters", {20'h0, aStall, aFlush, aFreeze}, 32'h0);
      endCycle();

      // Load-use via rs: LW to $8 in EX, ADD reading $8 in ID
      applyStimulus(5'd8, 5'd3, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      midCycle();
      checkOutput("loadUseEnables", 32'(enA()), 32'h07);
      checkOutput("loadUseFlushes", 32'(flA()), 32'h2);
      checkOutput("loadUseEnablesB", 32'(enB()), 32'h07);
      endCycle();
      idleInputs();
      midCycle();
      checkOutput("afterStallEnables", 32'(enA()), 32'h1F);
      checkOutput("stallCount1", 32'(aStall), 32'd1);
      endCycle();

      // Load into $zero never stalls
      applyStimulus(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      midCycle();
      checkOutput("zeroRegEnables", 32'(enA()), 32'h1F);
      checkOutput("zeroRegFlushes", 32'(flA()), 32'h0);
      endCycle();

      // rt match only counts when the ID instruction reads rt
      applyStimulus(5'd3, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      midCycle();
      checkOutput("rtUnusedEnables", 32'(enA()), 32'h1F);
      endCycle();
      applyStimulus(5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      midCycle();
      checkOutput("rtUsedEnables", 32'(enA()), 32'h07);
      checkOutput("stallCountStill1", 32'(aStall), 32'd1);
      endCycle();

      // Taken branch with a concurrent load-use: the redirect wins
      applyStimulus(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      midCycle();
      checkOutput("branchEnables", 32'(enA()), 32'h1F);
      checkOutput("branchFlushes", 32'(flA()), 32'h7);
      endCycle();
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      midCycle();
      checkOutput("flushCount1", 32'(aFlush), 32'd1);
      checkOutput("stallCount2", 32'(aStall), 32'd2);
      checkOutput("jumpFlushes", 32'(flA()), 32'h7);
      endCycle();
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      midCycle();
      checkOutput("jrFlushes", 32'(flA()), 32'h7);
      endCycle();
      idleInputs();
      midCycle();
      checkOutput("flushCount3", 32'(aFlush), 32'd3);
      endCycle();

      // SW in MEM with a 3-cycle memory: three frozen cycles, then RELEASE
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      midCycle();
      checkOutput("freeze1Enables", 32'(enA()), 32'h00);
      checkOutput("freeze1Flushes", 32'(flA()), 32'h0);
      checkOutput("freeze1Busy", 32'(aBusy), 32'h0);
      checkOutput("noFreezeEnablesB", 32'(enB()), 32'h1F);
      checkOutput("noFreezeBusyB", 32'(bBusy), 32'h0);
      endCycle();
      midCycle();
      checkOutput("freeze2Enables", 32'(enA()), 32'h00);
      checkOutput("freeze2Busy", 32'(aBusy), 32'h1);
      endCycle();
      midCycle();
      checkOutput("freeze3Enables", 32'(enA()), 32'h00);
      checkOutput("freeze3Busy", 32'(aBusy), 32'h1);
      endCycle();
      // RELEASE: the held access advances, and a load-use is still honoured
      applyStimulus(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      midCycle();
      checkOutput("releaseEnables", 32'(enA()), 32'h07);
      checkOutput("releaseFlushes", 32'(flA()), 32'h2);
      checkOutput("releaseBusy", 32'(aBusy), 32'h1);
      checkOutput("freezeCount3", 32'(aFreeze), 32'd3);
      endCycle();
      idleInputs();
      midCycle();
      checkOutput("postReleaseEnables", 32'(enA()), 32'h1F);
      checkOutput("postReleaseBusy", 32'(aBusy), 32'h0);
      checkOutput("stallCount3", 32'(aStall), 32'd3);
      checkOutput("freezeCountB", 32'(bFreeze), 32'd0);
      endCycle();

      // Reset on the second frozen cycle aborts the freeze
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      endCycle();
      reset = 1'b1;
      midCycle();
      checkOutput("waitBeforeResetBusy", 32'(aBusy), 32'h1);
      checkOutput("freezeCount4", 32'(aFreeze), 32'd4);
      endCycle();
      reset = 1'b0;
      idleInputs();
      midCycle();
      checkOutput("abortBusy", 32'(aBusy), 32'h0);
      checkOutput("abortEnables", 32'(enA()), 32'h1F);
      checkOutput("abortCounters", {20'h0, aStall, aFlush, aFreeze}, 32'h0);
      endCycle();

      // 17 redirects: the 4-bit counter wraps to 1, the 8-bit one reads 17
      for (int i = 0; i < 17; i++) begin
         applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0,
                       (i % 3) == 0, (i % 3) == 1, (i % 3) == 2, 1'b0, 1'b0);
         endCycle();
      end
      idleInputs();
      midCycle();
      checkOutput("flushWrapA", 32'(aFlush), 32'd1);
      checkOutput("flushCountB", 32'(bFlush), 32'd17);
      checkOutput("flushWrapEnables", 32'(enA()), 32'h1F);
      checkOutput("flushWrapFlushesB", 32'(flB()), 32'h0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
